// File: rtl/rdata_demux.sv
// AXI read-data demultiplexer: header beats into a flat register, then NUM_CH-beat groups
// into parallel channel FIFOs. Define RDATA_ID_CHECK_EN to enable RID checking against expect_id.
module rdata_demux #(
    parameter int unsigned DATA_W    = 1024,
    parameter int unsigned ID_WIDTH  = 2,
    parameter int unsigned HDR_BEATS = 6,
    parameter int unsigned NUM_CH    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             m_axi_rdata,
    input  logic [ID_WIDTH-1:0]           m_axi_rid,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    input  logic [1:0]                    m_axi_rresp,
    output logic                          m_axi_rready,
    input  logic                          start_pulse,
    input  logic [31:0]                   num_groups,
    input  logic [ID_WIDTH-1:0]           expect_id,
    output logic [HDR_BEATS*DATA_W-1:0]   hdr_data,
    output logic                          hdr_valid,
    output logic [NUM_CH*DATA_W-1:0]      fifo_din,
    input  logic [NUM_CH-1:0]             fifo_full,
    output logic [NUM_CH-1:0]             fifo_wr,
    output logic [31:0]                   group_cnt,
    output logic                          done,
    output logic                          busy,
    output logic                          rd_error,
    output logic [1:0]                    err_resp,
    output logic                          id_error
);

    localparam int unsigned HIDX_W = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam int unsigned CIDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    state_e              state_q;
    logic [HIDX_W-1:0]   hdr_idx_q;
    logic [CIDX_W-1:0]   ch_idx_q;
    logic [31:0]         num_groups_q;
    logic [31:0]         group_next;
    logic                accept;
    logic                id_ok;
    logic                last_hdr;
    logic                last_ch;

`ifdef RDATA_ID_CHECK_EN
    logic [ID_WIDTH-1:0] expect_id_q;
    logic                unused_rlast;
    assign id_ok        = (m_axi_rid == expect_id_q);
    assign unused_rlast = m_axi_rlast;
`else
    logic                unused_in;
    assign id_ok     = 1'b1;
    assign id_error  = 1'b0;
    assign unused_in = ^{m_axi_rlast, m_axi_rid, expect_id};
`endif

    assign last_hdr   = (hdr_idx_q == HIDX_W'(HDR_BEATS - 1));
    assign last_ch    = (ch_idx_q == CIDX_W'(NUM_CH - 1));
    assign group_next = group_cnt + 32'd1;
    assign accept     = m_axi_rvalid & m_axi_rready;
    assign busy       = (state_q != StIdle);

    // Stall the group-closing beat while any FIFO is full or the previous write is still out.
    always_comb begin
        m_axi_rready = 1'b1;
        if (state_q == StData && last_ch && ((|fifo_full) || (|fifo_wr))) begin
            m_axi_rready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            hdr_idx_q    <= '0;
            ch_idx_q     <= '0;
            num_groups_q <= '0;
            hdr_data     <= '0;
            hdr_valid    <= 1'b0;
            fifo_din     <= '0;
            fifo_wr      <= '0;
            group_cnt    <= '0;
            done         <= 1'b0;
            rd_error     <= 1'b0;
            err_resp     <= 2'b00;
`ifdef RDATA_ID_CHECK_EN
            expect_id_q  <= '0;
            id_error     <= 1'b0;
`endif
        end else begin
            hdr_valid <= 1'b0;
            fifo_wr   <= '0;
            done      <= 1'b0;
            if (start_pulse) begin
                state_q      <= StHdr;
                hdr_idx_q    <= '0;
                ch_idx_q     <= '0;
                group_cnt    <= '0;
                rd_error     <= 1'b0;
                err_resp     <= 2'b00;
                num_groups_q <= num_groups;
`ifdef RDATA_ID_CHECK_EN
                expect_id_q  <= expect_id;
                id_error     <= 1'b0;
`endif
            end else if (accept && state_q != StIdle) begin
                if (!id_ok) begin
`ifdef RDATA_ID_CHECK_EN
                    id_error <= 1'b1;
`endif
                end else begin
                    if (m_axi_rresp != 2'b00 && !rd_error) begin
                        rd_error <= 1'b1;
                        err_resp <= m_axi_rresp;
                    end
                    if (state_q == StHdr) begin
                        hdr_data[hdr_idx_q*DATA_W +: DATA_W] <= m_axi_rdata;
                        if (last_hdr) begin
                            hdr_valid <= 1'b1;
                            hdr_idx_q <= '0;
                            ch_idx_q  <= '0;
                            state_q   <= StData;
                        end else begin
                            hdr_idx_q <= hdr_idx_q + 1'b1;
                        end
                    end else begin
                        fifo_din[ch_idx_q*DATA_W +: DATA_W] <= m_axi_rdata;
                        if (last_ch) begin
                            fifo_wr   <= '1;
                            ch_idx_q  <= '0;
                            group_cnt <= group_next;
                            if (num_groups_q != 32'd0 && group_next == num_groups_q) begin
                                done      <= 1'b1;
                                hdr_idx_q <= '0;
                                state_q   <= StIdle;
                            end
                        end else begin
                            ch_idx_q <= ch_idx_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rdata_demux.sv
// Scoreboard bench for rdata_demux: a job-level model predicts headers and groups, a monitor
// pops and compares them whenever the DUT pulses hdr_valid or fifo_wr.
module tb_rdata_demux;

    localparam int DW   = 1024;
    localparam int IW   = 2;
    localparam int HB   = 6;
    localparam int NC   = 3;
    localparam int MAXW = ((HB > NC) ? HB : NC) * DW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     m_axi_rdata;
    logic [IW-1:0]     m_axi_rid;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rready;
    logic              start_pulse;
    logic [31:0]       num_groups;
    logic [IW-1:0]     expect_id;
    logic [HB*DW-1:0]  hdr_data;
    logic              hdr_valid;
    logic [NC*DW-1:0]  fifo_din;
    logic [NC-1:0]     fifo_full;
    logic [NC-1:0]     fifo_wr;
    logic [31:0]       group_cnt;
    logic              done;
    logic              busy;
    logic              rd_error;
    logic [1:0]        err_resp;
    logic              id_error;

    rdata_demux #(.DATA_W(DW), .ID_WIDTH(IW), .HDR_BEATS(HB), .NUM_CH(NC)) dut (
        .clk(clk), .rst_n(rst_n), .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rresp(m_axi_rresp),
        .m_axi_rready(m_axi_rready), .start_pulse(start_pulse), .num_groups(num_groups),
        .expect_id(expect_id), .hdr_data(hdr_data), .hdr_valid(hdr_valid),
        .fifo_din(fifo_din), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .group_cnt(group_cnt), .done(done), .busy(busy), .rd_error(rd_error),
        .err_resp(err_resp), .id_error(id_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC*DW-1:0] data;
        logic [31:0]      cnt;
        logic             done;
    } grp_t;

    logic [HB*DW-1:0] exp_hdr[$];
    grp_t             exp_grp[$];

    int checks = 0;
    int errors = 0;

    // Job-level reference model: m_k counts kept beats since the last start.
    int               m_st = 0;  // 0 idle, 1 header, 2 data
    int               m_k  = 0;
    logic [31:0]      m_cnt = '0;
    logic [31:0]      m_ng  = '0;
    logic [IW-1:0]    m_eid = '0;
    logic             m_rderr = 1'b0;
    logic [1:0]       m_eresp = 2'b00;
    logic             m_iderr = 1'b0;
    logic [HB*DW-1:0] m_hdr = '0;
    logic [NC*DW-1:0] m_grp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [MAXW-1:0] act,
                              input logic [MAXW-1:0] exp, input int n);
        int bad;
        bad = -1;
        for (int i = 0; i < n; i++) begin
            if (bad < 0 && act[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s slice %0d: got %0h expected %0h", name, bad,
                     act[bad*DW +: 64], exp[bad*DW +: 64]);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic exp_ready();
        if (m_st == 2 && ((m_k - HB) % NC) == NC - 1 && (|fifo_full)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_beat(input logic [DW-1:0] d, input logic [1:0] resp, input bit id_ok);
        grp_t g;
        int   c;
        if (m_st != 0) begin
            if (!id_ok) begin
                m_iderr = 1'b1;
            end else begin
                if (resp != 2'b00 && !m_rderr) begin
                    m_rderr = 1'b1;
                    m_eresp = resp;
                end
                if (m_k < HB) begin
                    m_hdr[m_k*DW +: DW] = d;
                    if (m_k == HB - 1) begin
                        exp_hdr.push_back(m_hdr);
                        m_st = 2;
                    end
                end else begin
                    c = (m_k - HB) % NC;
                    m_grp[c*DW +: DW] = d;
                    if (c == NC - 1) begin
                        m_cnt  = m_cnt + 32'd1;
                        g.data = m_grp;
                        g.cnt  = m_cnt;
                        g.done = (m_ng != 0 && m_cnt == m_ng);
                        exp_grp.push_back(g);
                        if (g.done) m_st = 0;
                    end
                end
                m_k++;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send(input logic [DW-1:0] d, input logic [1:0] resp, input logic [IW-1:0] rid,
                        input bit rnd_full);
        bit acc;
        bit ok;
        int tries;
        tries = 0;
        m_axi_rdata  = d;
        m_axi_rresp  = resp;
        m_axi_rid    = rid;
        m_axi_rvalid = 1'b1;
        ok = 1'b1;
`ifdef RDATA_ID_CHECK_EN
        ok = (rid == m_eid);
`endif
        do begin
            if (rnd_full) fifo_full = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
            #1;
            acc = m_axi_rready;
            check("rready", acc, exp_ready());
            @(posedge clk);
            if (acc) model_beat(d, resp, ok);
            @(negedge clk);
            tries++;
        end while (!acc && tries < 100);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        end
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
        if (rnd_full) fifo_full = '0;
    endtask

    task automatic start(input logic [31:0] ng, input logic [IW-1:0] eid, input bit junk);
        start_pulse = 1'b1;
        num_groups  = ng;
        expect_id   = eid;
        if (junk) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = rnd_data();
            m_axi_rresp  = 2'b11;
            m_axi_rid    = eid;
        end
        @(posedge clk);
        m_st = 1; m_k = 0; m_cnt = '0; m_ng = ng; m_eid = eid;
        m_rderr = 1'b0; m_eresp = 2'b00; m_iderr = 1'b0;
        @(negedge clk);
        start_pulse  = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".group_cnt"}, group_cnt, m_cnt);
        check({tag, ".busy"}, busy, (m_st != 0));
        check({tag, ".rd_error"}, rd_error, m_rderr);
        check({tag, ".err_resp"}, err_resp, m_eresp);
        check({tag, ".id_error"}, id_error, m_iderr);
    endtask

    // Monitor: every output event must match the next predicted one.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (hdr_valid) begin
                    if (exp_hdr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL hdr_valid: got pulse expected none");
                    end else begin
                        check_wide("hdr_data", MAXW'(hdr_data), MAXW'(exp_hdr.pop_front()), HB);
                    end
                end
                if (fifo_wr != '0) begin
                    check("fifo_wr", fifo_wr, {NC{1'b1}});
                    if (exp_grp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL fifo_wr: got write expected none");
                    end else begin
                        grp_t g;
                        g = exp_grp.pop_front();
                        check_wide("fifo_din", MAXW'(fifo_din), MAXW'(g.data), NC);
                        check("done", done, g.done);
                        check("wr_group_cnt", group_cnt, g.cnt);
                    end
                end else if (done) begin
                    checks++; errors++;
                    $display("FAIL done: got pulse expected none without fifo_wr");
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] stall_d;
        rst_n = 1'b0; m_axi_rdata = '0; m_axi_rid = '0; m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; start_pulse = 1'b0;
        num_groups = '0; expect_id = '0; fifo_full = '0;
        repeat (3) @(negedge clk);
        check("rst.hdr_data", (hdr_data == '0), 1'b1);
        check("rst.fifo_din", (fifo_din == '0), 1'b1);
        check("rst.outs", {hdr_valid, fifo_wr, done}, '0);
        check("rst.rready", m_axi_rready, 1'b1);
        check_status("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Header capture, then two groups back-to-back.
        start(32'd2, '0, 1'b0);
        for (int i = 0; i < HB; i++) send(DW'(32'h10 + i), 2'b00, '0, 1'b0);
        check("hdr_valid_pulse", hdr_valid, 1'b1);
        check("hdr_busy", busy, 1'b1);
        @(negedge clk);
        check("hdr_valid_once", hdr_valid, 1'b0);
        for (int i = 0; i < 2 * NC; i++) send(DW'(32'h100 + i), 2'b00, '0, 1'b0);
        check_status("two_groups");

        // Stall on the group-closing beat while one FIFO is full.
        start(32'd1, '0, 1'b0);
        for (int i = 0; i < HB + NC - 1; i++) send(rnd_data(), 2'b00, '0, 1'b0);
        stall_d = rnd_data();
        fifo_full = 3'b010;
        m_axi_rdata = stall_d; m_axi_rvalid = 1'b1; m_axi_rid = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_rready", m_axi_rready, exp_ready());
            @(negedge clk);
        end
        fifo_full = '0;
        send(stall_d, 2'b00, '0, 1'b0);
        check_status("stall");

        // Abort mid-group; the beat in the start cycle is dropped.
        start(32'd0, '0, 1'b0);
        for (int i = 0; i < HB + 1; i++) send(rnd_data(), 2'b01, '0, 1'b0);
        start(32'd1, '0, 1'b1);
        check_status("abort");
        for (int i = 0; i < HB + NC; i++) send(rnd_data(), 2'b00, '0, 1'b0);
        check_status("after_abort");

        // Error capture and RID mismatch on a data beat.
        start(32'd1, 2'd1, 1'b0);
        for (int i = 0; i < HB; i++) send(rnd_data(), (i == 3) ? 2'b10 : 2'b00, 2'd1, 1'b0);
        send(rnd_data(), 2'b11, 2'd1, 1'b0);
        send(rnd_data(), 2'b00, 2'd2, 1'b0);
        check_status("id_mismatch");
        for (int i = 0; i < NC; i++) send(rnd_data(), 2'b00, 2'd1, 1'b0);
        check_status("errors");

        // Randomized jobs with backpressure, idle beats and occasional aborts.
        for (int j = 0; j < 25; j++) begin
            logic [31:0]   ng;
            logic [IW-1:0] eid;
            int            budget;
            ng  = 32'($urandom_range(0, 4));
            eid = IW'($urandom);
            start(ng, eid, $urandom_range(0, 1) == 1);
            budget = HB + NC * ((ng == 0) ? 3 : int'(ng)) + 6;
            for (int i = 0; i < budget && m_st != 0; i++) begin
                logic [1:0]    rr;
                logic [IW-1:0] rid;
                rr  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                rid = ($urandom_range(0, 9) == 0) ? (eid ^ IW'(1)) : eid;
                d   = rnd_data();
                if ($urandom_range(0, 39) == 0) begin
                    start(32'($urandom_range(1, 3)), eid, 1'b1);
                    check_status("rnd_abort");
                end else begin
                    send(d, rr, rid, 1'b1);
                end
                if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            check_status("rnd_job");
            if (m_st == 0) begin
                send(rnd_data(), 2'b11, eid ^ IW'(1), 1'b0);
                check_status("idle_beat");
            end
        end

        repeat (4) @(negedge clk);
        check("hdr_queue_empty", exp_hdr.size(), 0);
        check("grp_queue_empty", exp_grp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
